// File: rtl/fir_step_sequencer.sv
// Step sequencer for the systolic low-pass FIR: one LOAD/STEP/SETTLE/CAPTURE pass per
// accepted audio sample, plus zero-sample history flush, priming status and drop counting.
module fir_step_sequencer #(
  parameter int STEP_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_TAPS      = 99,
  parameter int DROP_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_sample,
  input  logic [15:0]         sample_in,
  input  logic                flush,
  input  logic                clear_drops,
  output logic [15:0]         filt_sample,
  output logic                filt_enable,
  input  logic [15:0]         filt_result,
  output logic [15:0]         out_sample,
  output logic                out_valid,
  output logic                primed,
  output logic                busy,
  output logic [DROP_W-1:0]   drop_count
);

  localparam int TMR_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PRIME_W = $clog2(NUM_TAPS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    SETTLE,
    CAPTURE
  } state_t;

  state_t             state;
  logic               flush_mode;
  logic               flush_pending;
  logic [15:0]        hold_sample;
  logic [TMR_W-1:0]   tmr;
  logic [PRIME_W-1:0] prime_cnt;
  logic [PRIME_W-1:0] flush_cnt;

  logic start_flush;
  logic accept;
  logic drop;

  assign start_flush = (state == IDLE) && (flush || flush_pending);
  assign accept      = (state == IDLE) && new_sample && !flush && !flush_pending;
  assign drop        = new_sample && !accept;
  assign busy        = (state != IDLE) || flush_pending;

  // NOTE: every register below is written with <= so all branches see pre-edge values;
  // mixing in blocking writes would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flush_mode    <= 1'b0;
      flush_pending <= 1'b0;
      hold_sample   <= '0;
      tmr           <= '0;
      prime_cnt     <= '0;
      flush_cnt     <= '0;
      filt_sample   <= '0;
      filt_enable   <= 1'b0;
      out_sample    <= '0;
      out_valid     <= 1'b0;
      primed        <= 1'b0;
      drop_count    <= '0;
    end else begin
      out_valid <= 1'b0;

      if (clear_drops)
        drop_count <= '0;
      else if (drop && (drop_count != '1))
        drop_count <= drop_count + 1'b1;

      // A flush arriving mid-sample waits for the sample to finish; flush mode ignores it.
      if (flush && (state != IDLE) && !flush_mode)
        flush_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start_flush) begin
            flush_mode    <= 1'b1;
            flush_pending <= 1'b0;
            flush_cnt     <= '0;
            prime_cnt     <= '0;
            primed        <= 1'b0;
            state         <= LOAD;
          end else if (accept) begin
            // sample_in is only guaranteed alongside the strobe, so hold it for LOAD.
            hold_sample <= sample_in;
            flush_mode  <= 1'b0;
            state       <= LOAD;
          end
        end

        LOAD: begin
          filt_sample <= flush_mode ? 16'h0000 : hold_sample;
          filt_enable <= 1'b1;
          tmr         <= '0;
          state       <= STEP;
        end

        STEP: begin
          if (tmr == TMR_W'(STEP_CYCLES - 1)) begin
            filt_enable <= 1'b0;
            tmr         <= '0;
            state       <= (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        SETTLE: begin
          if (tmr == TMR_W'(SETTLE_CYCLES - 1))
            state <= CAPTURE;
          else
            tmr <= tmr + 1'b1;
        end

        CAPTURE: begin
          if (flush_mode) begin
            if (flush_cnt == PRIME_W'(NUM_TAPS - 1)) begin
              flush_mode <= 1'b0;
              state      <= IDLE;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
              state     <= LOAD;
            end
          end else begin
            out_sample <= filt_result;
            out_valid  <= 1'b1;
            if (prime_cnt != PRIME_W'(NUM_TAPS)) begin
              prime_cnt <= prime_cnt + 1'b1;
              if (prime_cnt == PRIME_W'(NUM_TAPS - 1))
                primed <= 1'b1;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
